// File: rtl/hyperram_rd_capture_ctrl.sv
// -----------------------------------------------------------------------------
// hyperram_rd_capture_ctrl
//
// Sequences the HyperRAM read-capture datapath built from the DDR input flops
// (8 DQ lanes plus RWDS). A read request pulses the IDDR reset, waits for
// RWDS-qualified data, assembles 16-bit words from rise/fall byte pairs and
// buffers them in a small FIFO that feeds a valid/ready stream. The burst
// length and a no-data timeout bound every read.
//
// Ports:
//   clk          system clock, same as the IDDR SCLK
//   rst          synchronous active-high reset
//   start        single-cycle read request, sampled only in IDLE
//   burst_len    number of words to capture, sampled with start
//   busy         high from the cycle after an accepted start through DONE
//   iddr_rst     reset to all read IDDRs, held FLUSH_CYC cycles per read
//   dq_ris       DQ IDDR Q0 (rising-edge byte, word MSB)
//   dq_fal       DQ IDDR Q1 (falling-edge byte, word LSB)
//   rwds_ris     RWDS IDDR Q0
//   rwds_fal     RWDS IDDR Q1
//   m_data       output word (0 while m_valid is low)
//   m_valid      output word valid
//   m_ready      consumer accept
//   done         one-cycle pulse at the end of a read
//   timeout_err  sticky: last read aborted on timeout
//   overflow     sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module hyperram_rd_capture_ctrl #(
    parameter int BURST_W    = 8,
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               busy,
    output logic               iddr_rst,
    input  logic [7:0]         dq_ris,
    input  logic [7:0]         dq_fal,
    input  logic               rwds_ris,
    input  logic               rwds_fal,
    output logic [15:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               done,
    output logic               timeout_err,
    output logic               overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // The idle counter only ever needs to hold 0..TIMEOUT-1: the abort
    // decision is taken on the cycle that would make it reach TIMEOUT.
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);

    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [FL_W-1:0]    FL_LAST  = FL_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0]   DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [BURST_W-1:0] LAST_ONE = BURST_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state;
    logic [BURST_W-1:0] remaining;
    logic [TO_W-1:0]    idle_cnt;
    logic [FL_W-1:0]    flush_cnt;

    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               vw;
    logic               capturing;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic [15:0]        word;

    // RWDS high on the rising half and low on the falling half marks a real
    // data beat; anything else (including both high) is a stall.
    assign vw        = rwds_ris & ~rwds_fal;
    assign word      = {dq_ris, dq_fal};
    assign capturing = (state == S_WAIT) || (state == S_CAPTURE);
    assign push      = capturing & vw;

    assign full    = (count == DEPTH);
    assign m_valid = (count != '0);
    assign pop     = m_valid & m_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign wr_en   = push & (~full | pop);

    // NOTE: the storage array has no reset; the output is gated with m_valid
    // so stale contents never reach m_data.
    assign m_data = m_valid ? mem[rd_ptr] : 16'h0000;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            remaining   <= '0;
            idle_cnt    <= '0;
            flush_cnt   <= '0;
            busy        <= 1'b0;
            iddr_rst    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // branch sees the values from the start of the cycle.
            done <= 1'b0;

            if (push && full && !pop) begin
                overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        timeout_err <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        if (burst_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= burst_len;
                            flush_cnt <= '0;
                            iddr_rst  <= 1'b1;
                            state     <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        iddr_rst <= 1'b0;
                        idle_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                S_WAIT, S_CAPTURE: begin
                    if (vw) begin
                        // remaining counts words seen, even ones dropped on a
                        // full FIFO, so the burst always ends on time.
                        remaining <= remaining - 1'b1;
                        idle_cnt  <= '0;
                        if (remaining == LAST_ONE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                        done        <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_rd_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hyperram_rd_capture_ctrl
//
// Directed bench for hyperram_rd_capture_ctrl with default parameters
// (BURST_W=8, TIMEOUT=64, FIFO_DEPTH=4, FLUSH_CYC=2). Inputs are driven and
// outputs observed on the falling clock edge; cyc() logs the finished cycle
// (done pulses, iddr_rst cycles, accepted words) and moves to the next one.
// -----------------------------------------------------------------------------
module tb_hyperram_rd_capture_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic        busy;
    logic        iddr_rst;
    logic [7:0]  dq_ris;
    logic [7:0]  dq_fal;
    logic        rwds_ris;
    logic        rwds_fal;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        done;
    logic        timeout_err;
    logic        overflow;

    int          checks;
    int          failures;
    int          done_cnt;
    int          irst_cnt;
    logic [15:0] popped[$];

    hyperram_rd_capture_ctrl #(
        .BURST_W    (8),
        .TIMEOUT    (64),
        .FIFO_DEPTH (4),
        .FLUSH_CYC  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .iddr_rst    (iddr_rst),
        .dq_ris      (dq_ris),
        .dq_fal      (dq_fal),
        .rwds_ris    (rwds_ris),
        .rwds_fal    (rwds_fal),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .done        (done),
        .timeout_err (timeout_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        if (done) done_cnt++;
        if (iddr_rst) irst_cnt++;
        if (m_valid && m_ready) popped.push_back(m_data);
        @(negedge clk);
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        irst_cnt = 0;
        popped.delete();
    endtask

    task automatic set_rwds(input logic vr, input logic vf,
                            input logic [7:0] r, input logic [7:0] f);
        rwds_ris = vr;
        rwds_fal = vf;
        dq_ris   = r;
        dq_fal   = f;
    endtask

    // Issues a start and returns at the first WAIT cycle (after 2 flush cycles).
    task automatic start_read(input logic [7:0] len);
        start     = 1'b1;
        burst_len = len;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, iddr_rst, m_valid, done, timeout_err, overflow} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, iddr_rst, m_valid, done, timeout_err, overflow});
        end
        checks++;
        if (m_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_m_data: got %h expected 0000", m_data);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        clear_stats();
        m_ready   = 1'b1;
        start     = 1'b1;
        burst_len = 8'd3;
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, iddr_rst} !== 2'b11) begin
            failures++;
            $display("FAIL basic_flush1: got busy/iddr_rst=%b expected 11", {busy, iddr_rst});
        end
        cyc();
        checks++;
        if (iddr_rst !== 1'b1) begin
            failures++;
            $display("FAIL basic_flush2: got iddr_rst=%b expected 1", iddr_rst);
        end
        cyc();
        checks++;
        if (iddr_rst !== 1'b0) begin
            failures++;
            $display("FAIL basic_wait: got iddr_rst=%b expected 0", iddr_rst);
        end
        set_rwds(1, 0, 8'hA1, 8'hB2); cyc();
        set_rwds(1, 0, 8'hC3, 8'hD4); cyc();
        set_rwds(1, 0, 8'hE5, 8'hF6); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if ({done, busy} !== 2'b11) begin
            failures++;
            $display("FAIL basic_done: got done/busy=%b expected 11", {done, busy});
        end
        cyc();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_after_done: got done/busy=%b expected 00", {done, busy});
        end
        repeat (3) cyc();
        checks++;
        if (popped.size() != 3 || done_cnt != 1 || irst_cnt != 2) begin
            failures++;
            $display("FAIL basic_counts: got words=%0d done=%0d iddr_rst=%0d expected 3 1 2",
                     popped.size(), done_cnt, irst_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= popped.size() || popped[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_word%0d: got %h expected %h", i,
                         (i < popped.size()) ? popped[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_stalls();
        clear_stats();
        m_ready = 1'b1;
        start_read(8'd2);
        set_rwds(1, 0, 8'h11, 8'h22); cyc();
        set_rwds(1, 1, 8'hEE, 8'hEE); cyc();
        cyc();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL stall_early_done: got %b expected 0", done);
        end
        set_rwds(1, 0, 8'h33, 8'h44); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done: got %b expected 1", done);
        end
        repeat (4) cyc();
        checks++;
        if (popped.size() != 2 || timeout_err !== 1'b0 || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_counts: got words=%0d timeout_err=%b done=%0d expected 2 0 1",
                     popped.size(), timeout_err, done_cnt);
        end
        checks++;
        if (popped.size() != 2 || popped[0] !== 16'h1122 || popped[1] !== 16'h3344) begin
            failures++;
            $display("FAIL stall_words: got %p expected 1122 3344", popped);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] first_w;
        clear_stats();
        m_ready = 1'b0;
        start_read(8'd6);
        for (int i = 0; i < 6; i++) begin
            set_rwds(1, 0, 8'(8'h10 + i), 8'(8'h20 + i));
            cyc();
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_at_full: got %b expected 0", overflow);
                end
            end
        end
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if ({done, overflow, m_valid} !== 3'b111) begin
            failures++;
            $display("FAIL ovf_done: got done/overflow/m_valid=%b expected 111",
                     {done, overflow, m_valid});
        end
        first_w = 16'h1020;
        repeat (3) cyc();
        checks++;
        if (m_data !== first_w || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold: got m_data=%h busy=%b expected %h 0", m_data, busy, first_w);
        end
        m_ready = 1'b1;
        repeat (5) cyc();
        checks++;
        if (popped.size() != 4 || popped[0] !== 16'h1020 || popped[1] !== 16'h1121 ||
            popped[2] !== 16'h1222 || popped[3] !== 16'h1323 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain: got %p m_valid=%b expected 1020 1121 1222 1323 0",
                     popped, m_valid);
        end
    endtask

    task automatic test_timeout();
        int k;
        clear_stats();
        m_ready = 1'b0;
        start_read(8'd4);
        set_rwds(1, 0, 8'h5A, 8'hA5); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        // The word is visible now; done must follow exactly 64 cycles later.
        k = 0;
        while (!done && k < 200) begin
            cyc();
            k++;
        end
        checks++;
        if (k != 64) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected 64", k);
        end
        checks++;
        if ({timeout_err, m_valid} !== 2'b11 || m_data !== 16'h5AA5) begin
            failures++;
            $display("FAIL timeout_state: got err/valid=%b data=%h expected 11 5aa5",
                     {timeout_err, m_valid}, m_data);
        end
        cyc();
        // Next read clears the flag and delivers the leftover word first.
        clear_stats();
        start     = 1'b1;
        burst_len = 8'd1;
        cyc();
        start = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        m_ready = 1'b1;
        repeat (2) cyc();
        set_rwds(1, 0, 8'h77, 8'h88); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        repeat (4) cyc();
        checks++;
        if (popped.size() != 2 || popped[0] !== 16'h5AA5 || popped[1] !== 16'h7788) begin
            failures++;
            $display("FAIL timeout_leftover: got %p expected 5aa5 7788", popped);
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        start     = 1'b1;
        burst_len = 8'd0;
        cyc();
        start = 1'b0;
        checks++;
        if ({done, busy, iddr_rst} !== 3'b110) begin
            failures++;
            $display("FAIL zero_done: got done/busy/iddr_rst=%b expected 110",
                     {done, busy, iddr_rst});
        end
        cyc();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL zero_idle: got done/busy=%b expected 00", {done, busy});
        end
        repeat (2) cyc();
        checks++;
        if (irst_cnt != 0 || popped.size() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL zero_counts: got iddr_rst=%0d words=%0d done=%0d expected 0 0 1",
                     irst_cnt, popped.size(), done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        clear_stats();
        m_ready = 1'b1;
        start_read(8'd2);
        start     = 1'b1;
        burst_len = 8'd5;
        cyc();
        start = 1'b0;
        set_rwds(1, 0, 8'hAB, 8'hCD); cyc();
        start     = 1'b1;
        burst_len = 8'd7;
        set_rwds(1, 0, 8'hEF, 8'h01); cyc();
        start = 1'b0;
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_done: got %b expected 1", done);
        end
        repeat (4) cyc();
        checks++;
        if (done_cnt != 1 || popped.size() != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_counts: got done=%0d words=%0d busy=%b expected 1 2 0",
                     done_cnt, popped.size(), busy);
        end
    endtask

    task automatic test_full_pop();
        clear_stats();
        m_ready = 1'b0;
        start_read(8'd5);
        for (int i = 0; i < 4; i++) begin
            set_rwds(1, 0, 8'(8'h30 + i), 8'(8'h40 + i));
            cyc();
        end
        m_ready = 1'b1;
        set_rwds(1, 0, 8'h34, 8'h44); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if ({done, overflow} !== 2'b10) begin
            failures++;
            $display("FAIL fullpop_flags: got done/overflow=%b expected 10", {done, overflow});
        end
        repeat (5) cyc();
        checks++;
        if (popped.size() != 5 || popped[0] !== 16'h3040 || popped[4] !== 16'h3444) begin
            failures++;
            $display("FAIL fullpop_words: got %p expected 3040 .. 3444 (5 words)", popped);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        m_ready = 1'b0;
        start_read(8'd5);
        set_rwds(1, 0, 8'h61, 8'h62); cyc();
        set_rwds(1, 0, 8'h63, 8'h64); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        checks++;
        if ({busy, m_valid} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_before: got busy/m_valid=%b expected 11", {busy, m_valid});
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({busy, m_valid, done, iddr_rst} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_after: got busy/m_valid/done/iddr_rst=%b expected 0000",
                     {busy, m_valid, done, iddr_rst});
        end
        repeat (3) cyc();
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt);
        end
        clear_stats();
        m_ready = 1'b1;
        start_read(8'd1);
        set_rwds(1, 0, 8'h71, 8'h72); cyc();
        set_rwds(0, 0, 8'h00, 8'h00);
        repeat (3) cyc();
        checks++;
        if (popped.size() != 1 || popped[0] !== 16'h7172 || done_cnt != 1) begin
            failures++;
            $display("FAIL rstmid_restart: got %p done=%0d expected 7172 1", popped, done_cnt);
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        burst_len = 8'd0;
        m_ready   = 1'b0;
        checks    = 0;
        failures  = 0;
        set_rwds(0, 0, 8'h00, 8'h00);
        clear_stats();

        test_reset();
        test_basic();
        test_stalls();
        test_overflow();
        test_timeout();
        test_zero_len();
        test_start_ignored();
        test_full_pop();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
